ln_stat_dispatch: RTL and testbench

//  Upstream partner of the LayerNorm affine stage. Buffers one token frame of N signed 9-bit

---
 rtl/ln_stat_dispatch.sv | 165 ++++++++++++++++
 tb/tb_ln_stat_dispatch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ln_stat_dispatch.sv
// ln_stat_dispatch: collects one frame of N shifted activations, derives the
// frame mean and a Q0.8 reciprocal standard deviation, then replays the frame
// one element at a time to the LayerNorm affine stage.
//
// Handshakes:
//   input  - an element is taken on a rising edge where i_valid & o_ready;
//            o_ready is high only while collecting, and i_valid without
//            o_ready is dropped.
//   output - o_valid is a single-cycle pulse carrying o_x_norm/o_alpha. The
//            next pulse waits for i_affine_done from the affine stage. A done
//            that arrives while nothing is outstanding is ignored.
module ln_stat_dispatch #(
  parameter int N_LOG2 = 3
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  logic [8:0]  i_x,
  input  logic [1:0]  i_alpha,
  output logic        o_ready,
  output logic        o_valid,
  output logic [8:0]  o_x_norm,
  output logic [1:0]  o_alpha,
  output logic [21:0] o_mean,
  output logic [7:0]  o_std,
  input  logic        i_affine_done,
  output logic        o_frame_done
);

  localparam int N   = 1 << N_LOG2;
  localparam int SQW = 21 + N_LOG2;
  localparam logic [N_LOG2-1:0] IDX_ONE  = 1;
  localparam logic [N_LOG2-1:0] IDX_LAST = N_LOG2'(N - 1);

  typedef enum logic [2:0] {
    S_COLLECT, S_MEAN, S_VAR, S_ISQ, S_ISSUE, S_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [N_LOG2-1:0]  r_count, r_idx, w_idx_nxt;
  logic [8:0]         r_buf_x [N];
  logic [1:0]         r_buf_a [N];
  logic signed [21:0] r_sum, r_mean;
  logic [SQW-1:0]     r_sq;
  logic [20:0]        r_var;
  logic [7:0]         r_std_work, r_std;
  logic [2:0]         r_bit;
  logic [8:0]         r_x_out;
  logic [1:0]         r_a_out;

  logic               w_accept, w_last_done, w_keep;
  logic signed [10:0] w_s;
  logic signed [20:0] w_s_sq;
  logic [20:0]        w_sq_div, w_var_diff;
  logic [43:0]        w_msq;
  logic               w_var_neg;
  logic [7:0]         w_cand;
  logic [39:0]        w_prod;

  assign w_accept    = i_valid && (r_state == S_COLLECT);
  assign w_last_done = (r_state == S_WAIT) && i_affine_done && (r_idx == IDX_LAST);
  assign w_idx_nxt   = ((r_state == S_WAIT) && i_affine_done) ? r_idx + IDX_ONE : r_idx;

  // PTF shift into the 11-bit working domain; the square always fits 21 bits unsigned.
  assign w_s    = $signed({{2{i_x[8]}}, i_x}) <<< i_alpha;
  assign w_s_sq = w_s * w_s;

  // Variance: E[s^2] - mean^2, negative results clamp to zero.
  assign w_sq_div   = r_sq[SQW-1:N_LOG2];
  assign w_msq      = r_mean * r_mean;
  assign w_var_neg  = w_msq > {23'd0, w_sq_div};
  assign w_var_diff = w_sq_div - w_msq[20:0];

  // One step of the MSB-first search for the largest c with c*c*var <= 2^16.
  assign w_cand = r_std_work | (8'd1 << r_bit);
  assign w_prod = {32'd0, w_cand} * {32'd0, w_cand} * {19'd0, r_var};
  assign w_keep = w_prod <= 40'd65536;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= S_COLLECT;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && r_count == IDX_LAST) w_state_nxt = S_MEAN;
      S_MEAN:    w_state_nxt = S_VAR;
      S_VAR:     w_state_nxt = S_ISQ;
      S_ISQ:     if (r_bit == 3'd0) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_WAIT;
      S_WAIT:    if (i_affine_done) w_state_nxt = (r_idx == IDX_LAST) ? S_COLLECT : S_ISSUE;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Output decode
  always_comb begin
    o_ready      = (r_state == S_COLLECT);
    o_valid      = (r_state == S_ISSUE);
    o_frame_done = w_last_done;
  end

  // Frame buffer; contents are only meaningful below r_count, so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf_x[r_count] <= i_x;
      r_buf_a[r_count] <= i_alpha;
    end
  end

  // Statistics datapath, replay index and replay output registers
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_sq       <= '0;
      r_mean     <= '0;
      r_var      <= '0;
      r_std_work <= '0;
      r_std      <= '0;
      r_bit      <= '0;
      r_x_out    <= '0;
      r_a_out    <= '0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + IDX_ONE;
        r_sum   <= r_sum + {{11{w_s[10]}}, w_s};
        r_sq    <= r_sq + {{N_LOG2{1'b0}}, w_s_sq};
      end
      if (r_state == S_MEAN) r_mean <= r_sum >>> N_LOG2;
      if (r_state == S_VAR) begin
        r_var      <= w_var_neg ? 21'd0 : w_var_diff;
        r_std_work <= '0;
        r_bit      <= 3'd7;
      end
      if (r_state == S_ISQ) begin
        r_std_work <= w_keep ? w_cand : r_std_work;
        r_bit      <= r_bit - 3'd1;
        if (r_bit == 3'd0) r_std <= w_keep ? w_cand : r_std_work;
      end
      if (r_state == S_WAIT && i_affine_done) r_idx <= w_idx_nxt;
      if (w_state_nxt == S_ISSUE) begin
        r_x_out <= r_buf_x[w_idx_nxt];
        r_a_out <= r_buf_a[w_idx_nxt];
      end
      if (w_last_done) begin
        r_count <= '0;
        r_idx   <= '0;
        r_sum   <= '0;
        r_sq    <= '0;
      end
    end
  end

  assign o_x_norm = r_x_out;
  assign o_alpha  = r_a_out;
  assign o_mean   = r_mean;
  assign o_std    = r_std;

endmodule

// File: tb/tb_ln_stat_dispatch.sv
// Directed testbench for ln_stat_dispatch (N_LOG2 = 3, N = 8). Frames come
// from small tables with hand-computed mean / std; replayed elements are
// checked in order against an expected queue.
module tb_ln_stat_dispatch;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        i_rstn, i_valid, i_affine_done;
  logic [8:0]  i_x;
  logic [1:0]  i_alpha;
  logic        o_ready, o_valid, o_frame_done;
  logic [8:0]  o_x_norm;
  logic [1:0]  o_alpha;
  logic [21:0] o_mean;
  logic [7:0]  o_std;

  ln_stat_dispatch #(.N_LOG2(3)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_x(i_x), .i_alpha(i_alpha),
    .o_ready(o_ready), .o_valid(o_valid), .o_x_norm(o_x_norm), .o_alpha(o_alpha),
    .o_mean(o_mean), .o_std(o_std), .i_affine_done(i_affine_done),
    .o_frame_done(o_frame_done)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  int fr_x [N];
  int fr_a [N];
  int acc_cyc  = 0;
  int done_cyc = 0;
  int vcount   = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts o_valid pulses and flags two in a row.
  always @(negedge clk) begin
    if (o_valid) begin
      chk("valid_back_to_back", int'(prev_v), 0);
      vcount++;
    end
    prev_v = o_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input bit spur_collect);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("ready_collect", int'(o_ready), 1);
      i_valid = 1'b1;
      i_x     = 9'(fr_x[i]);
      i_alpha = 2'(fr_a[i]);
      exp_q.push_back({i_alpha, i_x});
      if (spur_collect && i == 3) begin
        i_affine_done = 1'b1;
        #1 chk("frame_done_spur_collect", int'(o_frame_done), 0);
      end else begin
        i_affine_done = 1'b0;
      end
      acc_cyc = cyc;
    end
    @(negedge clk);
    i_valid       = 1'b0;
    i_affine_done = 1'b0;
  endtask

  // Affine-stage model: answers each o_valid with done 2-3 cycles later.
  task automatic replay(input int em, input int es, input bit spur_issue);
    int v0;
    int wt;
    logic [10:0] e;
    v0 = vcount;
    for (int i = 0; i < N; i++) begin
      wt = 0;
      while (!o_valid && wt < 40) begin
        @(negedge clk);
        wt++;
      end
      if (!o_valid) begin
        chk("valid_timeout", 0, 1);
        exp_q.delete();
        return;
      end
      if (i == 0) chk("first_valid_latency", cyc - acc_cyc, 11);
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", 0, 1);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      chk("x_norm", int'($signed(o_x_norm)), int'($signed(e[8:0])));
      chk("alpha", int'(o_alpha), int'(e[10:9]));
      chk("mean", int'($signed(o_mean)), em);
      chk("std", int'(o_std), es);
      if (spur_issue && i == 2) begin
        i_affine_done = 1'b1;
        #1 chk("frame_done_spur_issue", int'(o_frame_done), 0);
        @(negedge clk);
        i_affine_done = 1'b0;
        chk("no_valid_after_spur", int'(o_valid), 0);
        @(negedge clk);
      end else begin
        @(negedge clk);
        @(negedge clk);
      end
      chk("valid_low_in_wait", int'(o_valid), 0);
      i_affine_done = 1'b1;
      #1 chk("frame_done", int'(o_frame_done), (i == N - 1) ? 1 : 0);
      if (i == N - 1) done_cyc = cyc;
      @(negedge clk);
      i_affine_done = 1'b0;
    end
    chk("valid_count", vcount - v0, N);
    chk("ready_after_frame", int'(o_ready), 1);
  endtask

  task automatic run_frame(input int em, input int es, input bit spur_c, input bit spur_i);
    send_frame(spur_c);
    replay(em, es, spur_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    i_rstn = 1'b0; i_valid = 1'b0; i_x = '0; i_alpha = '0; i_affine_done = 1'b0;
    repeat (3) @(negedge clk);
    i_rstn = 1'b1;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_frame_done", int'(o_frame_done), 0);
    chk("rst_x_norm", int'(o_x_norm), 0);
    chk("rst_alpha", int'(o_alpha), 0);
    chk("rst_mean", int'(o_mean), 0);
    chk("rst_std", int'(o_std), 0);

    // T1: reset in the middle of the reciprocal-std search
    fr_x = '{10, 20, 30, 40, 50, 60, 70, 80};
    fr_a = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    i_rstn = 1'b0;
    @(negedge clk);
    i_rstn = 1'b1;
    chk("t1_ready", int'(o_ready), 1);
    chk("t1_valid", int'(o_valid), 0);
    chk("t1_mean", int'(o_mean), 0);
    chk("t1_std", int'(o_std), 0);
    v0 = vcount;
    i_affine_done = 1'b1;
    #1 chk("t1_frame_done", int'(o_frame_done), 0);
    @(negedge clk);
    i_affine_done = 1'b0;
    repeat (15) @(negedge clk);
    chk("t1_no_valid", vcount - v0, 0);
    exp_q.delete();

    // T2: constant frame, zero variance
    fr_x = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_frame(5, 255, 1'b0, 1'b0);

    // T3: +-2 alpha 0, then +-1 alpha 1 -> same statistics
    fr_x = '{2, -2, 2, -2, 2, -2, 2, -2};
    run_frame(0, 128, 1'b0, 1'b0);
    fr_x = '{1, -1, 1, -1, 1, -1, 1, -1};
    fr_a = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_frame(0, 128, 1'b0, 1'b0);

    // T4: floor of a negative mean and variance clamp
    fr_x = '{-1, 0, 0, 0, 0, 0, 0, 0};
    fr_a = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(-1, 255, 1'b0, 1'b0);
    fr_x = '{-3, -3, -3, -3, -3, -3, -3, -3};
    run_frame(-3, 255, 1'b0, 1'b0);

    // Non-trivial variance: SUM=8, SQ=64 -> mean 1, var 7, std 96
    fr_x = '{0, 0, 0, 0, 0, 0, 0, 8};
    run_frame(1, 96, 1'b0, 1'b0);

    // T5: mixed alphas (all |s|=8 -> var 64, std 32) with spurious dones
    fr_x = '{8, -8, 4, -4, 2, -2, 1, -1};
    fr_a = '{0, 0, 1, 1, 2, 2, 3, 3};
    run_frame(0, 32, 1'b1, 1'b1);

    // T6: i_valid held high across the replay of frame A (mean 13, var 18, std 60);
    // the held value x=3 becomes frame B starting after o_frame_done
    fr_x = '{10, 11, 12, 13, 14, 15, 16, 17};
    fr_a = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1'b0);
    i_valid = 1'b1; i_x = 9'd3; i_alpha = 2'd0;
    replay(13, 60, 1'b0);
    for (int i = 0; i < N; i++) exp_q.push_back({2'd0, 9'd3});
    acc_cyc = done_cyc + N;
    while (cyc < done_cyc + N + 1) @(negedge clk);
    i_valid = 1'b0;
    replay(3, 255, 1'b0);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
